// File: rtl/eight_bit_machine.sv
// eight_bit_machine: multi-cycle 8-bit CPU plus 256x8 unified instruction/data RAM.
// Optional build macro MACHINE_ILLEGAL_HALT_EN: when defined, unlisted opcodes halt
// the machine like HLT; otherwise they execute as 3-cycle NOPs.

module eight_bit_machine_ram (
  input  logic       i_clk,
  input  logic [7:0] i_addr,
  input  logic       i_we,
  input  logic [7:0] i_wdata,
  output logic [7:0] o_rdata
);
  logic [7:0] mem [0:255];
  logic [7:0] r_rdata;

  // Synchronous write; registered read gives one cycle of read latency.
  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_addr] <= i_wdata;
    r_rdata <= mem[i_addr];
  end

  assign o_rdata = r_rdata;
endmodule

module eight_bit_machine_regs (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_we,
  input  logic [2:0] i_waddr,
  input  logic [7:0] i_wdata,
  input  logic [2:0] i_raddr,
  output logic [7:0] o_rdata,
  output logic [7:0] o_rega
);
  logic [7:0] rega, regb, regc, regd, rege, regf, regg, regt;

  // Single write port; index 7 is the T register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rega <= 8'h00; regb <= 8'h00; regc <= 8'h00; regd <= 8'h00;
      rege <= 8'h00; regf <= 8'h00; regg <= 8'h00; regt <= 8'h00;
    end else if (i_we) begin
      case (i_waddr)
        3'd0:    rega <= i_wdata;
        3'd1:    regb <= i_wdata;
        3'd2:    regc <= i_wdata;
        3'd3:    regd <= i_wdata;
        3'd4:    rege <= i_wdata;
        3'd5:    regf <= i_wdata;
        3'd6:    regg <= i_wdata;
        default: regt <= i_wdata;
      endcase
    end
  end

  // Asynchronous read port selected by the instruction's source field.
  always_comb begin
    o_rdata = rega;
    case (i_raddr)
      3'd0:    o_rdata = rega;
      3'd1:    o_rdata = regb;
      3'd2:    o_rdata = regc;
      3'd3:    o_rdata = regd;
      3'd4:    o_rdata = rege;
      3'd5:    o_rdata = regf;
      3'd6:    o_rdata = regg;
      default: o_rdata = regt;
    endcase
  end

  assign o_rega = rega;
endmodule

module eight_bit_machine_cpu (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_rdata,
  output logic [7:0] o_addr,
  output logic       o_we,
  output logic [7:0] o_wdata,
  output logic       halted,
  output logic [7:0] o_pc
);
  typedef enum logic [2:0] {
    StFetch, StDecode, StOpFetch, StOpLatch, StMemRd, StExec, StHalt
  } state_e;

  state_e     r_state, w_state_next;
  logic [7:0] r_pc, r_ir, r_operand;
  logic       r_flag_z, r_flag_c, r_halted;

  logic [7:0] w_src, w_rega, w_alu_res, w_reg_wdata;
  logic       w_alu_c, w_reg_we, w_taken, w_halt_now;
  logic [2:0] w_reg_waddr;
  logic       w_ldi, w_ld, w_st, w_mov, w_alu, w_jump, w_hlt;

  // Opcodes that carry an operand byte: LDI/LD/ST and JMP/Jcc.
  function automatic logic f_two_byte(input logic [7:0] op);
    return ((op[7:5] == 3'b000) && (op[4:3] != 2'b00)) ||
           ((op[7:3] == 5'b11000) && (op[2:0] <= 3'd4));
  endfunction

  assign w_ldi  = (r_ir[7:3] == 5'b00001);
  assign w_ld   = (r_ir[7:3] == 5'b00010);
  assign w_st   = (r_ir[7:3] == 5'b00011);
  assign w_mov  = (r_ir[7:6] == 2'b01);
  assign w_alu  = (r_ir[7:6] == 2'b10);
  assign w_jump = (r_ir[7:3] == 5'b11000) && (r_ir[2:0] <= 3'd4);
  assign w_hlt  = (r_ir == 8'h01);

`ifdef MACHINE_ILLEGAL_HALT_EN
  logic w_illegal;
  assign w_illegal  = !(w_ldi || w_ld || w_st || w_mov || w_alu || w_jump || w_hlt ||
                        (r_ir == 8'h00));
  assign w_halt_now = w_hlt || w_illegal;
`else
  assign w_halt_now = w_hlt;
`endif

  eight_bit_machine_regs m_registers (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (w_reg_we),
    .i_waddr (w_reg_waddr),
    .i_wdata (w_reg_wdata),
    .i_raddr (r_ir[2:0]),
    .o_rdata (w_src),
    .o_rega  (w_rega)
  );

  // ALU on A with the selected source; C is carry, borrow or shifted-out bit.
  always_comb begin
    w_alu_res = w_rega;
    w_alu_c   = 1'b0;
    case (r_ir[5:3])
      3'd0:       {w_alu_c, w_alu_res} = {1'b0, w_rega} + {1'b0, w_src};
      3'd1, 3'd5: begin
        w_alu_res = w_rega - w_src;
        w_alu_c   = (w_rega < w_src);
      end
      3'd2:       w_alu_res = w_rega & w_src;
      3'd3:       w_alu_res = w_rega | w_src;
      3'd4:       w_alu_res = w_rega ^ w_src;
      3'd6:       begin
        w_alu_res = {w_rega[6:0], 1'b0};
        w_alu_c   = w_rega[7];
      end
      default:    begin
        w_alu_res = {1'b0, w_rega[7:1]};
        w_alu_c   = w_rega[0];
      end
    endcase
  end

  // Branch condition: JMP, JZ, JNZ, JC, JNC.
  always_comb begin
    w_taken = 1'b0;
    case (r_ir[2:0])
      3'd0:    w_taken = 1'b1;
      3'd1:    w_taken = r_flag_z;
      3'd2:    w_taken = !r_flag_z;
      3'd3:    w_taken = r_flag_c;
      3'd4:    w_taken = !r_flag_c;
      default: w_taken = 1'b0;
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StFetch;
    else          r_state <= w_state_next;
  end

  // FSM next state; the opcode is still on the RAM read port during DECODE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StFetch:   w_state_next = StDecode;
      StDecode:  w_state_next = f_two_byte(i_rdata) ? StOpFetch : StExec;
      StOpFetch: w_state_next = StOpLatch;
      StOpLatch: w_state_next = w_ld ? StMemRd : StExec;
      StMemRd:   w_state_next = StExec;
      StExec:    w_state_next = w_halt_now ? StHalt : StFetch;
      default:   w_state_next = StHalt;
    endcase
  end

  // FSM outputs: RAM address/write strobe and register-file write port.
  always_comb begin
    o_addr      = r_pc;
    o_we        = 1'b0;
    o_wdata     = w_src;
    w_reg_we    = 1'b0;
    w_reg_waddr = r_ir[2:0];
    w_reg_wdata = r_operand;
    case (r_state)
      StMemRd: o_addr = r_operand;
      StExec: begin
        if (w_st) begin
          o_addr = r_operand;
          o_we   = 1'b1;
        end
        if (w_ldi) w_reg_we = 1'b1;
        if (w_ld) begin
          w_reg_we    = 1'b1;
          w_reg_wdata = i_rdata;
        end
        if (w_mov) begin
          w_reg_we    = 1'b1;
          w_reg_waddr = r_ir[5:3];
          w_reg_wdata = w_src;
        end
        // CMP only updates flags.
        if (w_alu && (r_ir[5:3] != 3'd5)) begin
          w_reg_we    = 1'b1;
          w_reg_waddr = 3'd0;
          w_reg_wdata = w_alu_res;
        end
      end
      default: ;
    endcase
  end

  // PC, IR, operand, flags and halt flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc      <= 8'h00;
      r_ir      <= 8'h00;
      r_operand <= 8'h00;
      r_flag_z  <= 1'b0;
      r_flag_c  <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      case (r_state)
        StDecode: begin
          r_ir <= i_rdata;
          r_pc <= r_pc + 8'd1;
        end
        StOpLatch: begin
          r_operand <= i_rdata;
          r_pc      <= r_pc + 8'd1;
        end
        StExec: begin
          if (w_alu) begin
            r_flag_z <= (w_alu_res == 8'h00);
            r_flag_c <= w_alu_c;
          end
          if (w_jump && w_taken) r_pc <= r_operand;
          if (w_halt_now) r_halted <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign halted = r_halted;
  assign o_pc   = r_pc;
endmodule

module eight_bit_machine (
  input  logic       clk,
  input  logic       reset,
  output logic       halted,
  output logic [7:0] dbg_pc
);
  logic [7:0] w_addr, w_wdata, w_rdata;
  logic       w_we;

  eight_bit_machine_ram m_ram (
    .i_clk   (clk),
    .i_addr  (w_addr),
    .i_we    (w_we),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  eight_bit_machine_cpu m_cpu (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_rdata (w_rdata),
    .o_addr  (w_addr),
    .o_we    (w_we),
    .o_wdata (w_wdata),
    .halted  (halted),
    .o_pc    (dbg_pc)
  );
endmodule

// File: tb/tb_eight_bit_machine.sv
// tb_eight_bit_machine: directed and random programs checked against an ISA-level model.
// Honours MACHINE_ILLEGAL_HALT_EN the same way as the design.

module tb_eight_bit_machine;
  logic       clk = 1'b0;
  logic       reset;
  logic       halted;
  logic [7:0] dbg_pc;

  int total = 0;
  int bad   = 0;

  logic [7:0] img [256];
  logic [7:0] mm  [256];
  logic [7:0] rm  [8];
  logic [7:0] mpc;
  logic       mz, mc, mhalt;
  int         mcyc;

  eight_bit_machine dut (
    .clk    (clk),
    .reset  (reset),
    .halted (halted),
    .dbg_pc (dbg_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] dut_reg(input int i);
    case (i)
      0:       return dut.m_cpu.m_registers.rega;
      1:       return dut.m_cpu.m_registers.regb;
      2:       return dut.m_cpu.m_registers.regc;
      3:       return dut.m_cpu.m_registers.regd;
      4:       return dut.m_cpu.m_registers.rege;
      5:       return dut.m_cpu.m_registers.regf;
      6:       return dut.m_cpu.m_registers.regg;
      default: return dut.m_cpu.m_registers.regt;
    endcase
  endfunction

  // Instruction-level interpreter: whole instructions at a time, with cycle costs.
  task automatic run_model();
    logic [7:0] op, opd;
    int av, sv, res, fn;
    logic take;
    for (int i = 0; i < 256; i++) mm[i] = img[i];
    for (int i = 0; i < 8; i++) rm[i] = 8'h00;
    mpc = 8'h00; mz = 1'b0; mc = 1'b0; mhalt = 1'b0; mcyc = 0;
    while (!mhalt && mcyc < 20000) begin
      op  = mm[mpc];
      mpc = mpc + 8'd1;
      opd = 8'h00;
      if (op inside {[8'h08:8'h1F], [8'hC0:8'hC4]}) begin
        opd  = mm[mpc];
        mpc  = mpc + 8'd1;
        mcyc += (op >= 8'h10 && op <= 8'h17) ? 6 : 5;
      end else begin
        mcyc += 3;
      end
      if (op == 8'h01) mhalt = 1'b1;
      else if (op >= 8'h08 && op <= 8'h0F) rm[op % 8] = opd;
      else if (op >= 8'h10 && op <= 8'h17) rm[op % 8] = mm[opd];
      else if (op >= 8'h18 && op <= 8'h1F) mm[opd] = rm[op % 8];
      else if (op >= 8'h40 && op <= 8'h7F) rm[(op / 8) % 8] = rm[op % 8];
      else if (op >= 8'h80 && op <= 8'hBF) begin
        fn = (op / 8) % 8;
        av = int'(rm[0]);
        sv = int'(rm[op % 8]);
        res = av;
        case (fn)
          0: begin res = av + sv; mc = (res > 255); end
          1, 5: begin res = av - sv; mc = (av < sv); if (res < 0) res += 256; end
          2: begin res = av & sv; mc = 1'b0; end
          3: begin res = av | sv; mc = 1'b0; end
          4: begin res = av ^ sv; mc = 1'b0; end
          6: begin res = av * 2; mc = (av >= 128); end
          default: begin res = av / 2; mc = (av % 2 == 1); end
        endcase
        res = res % 256;
        mz  = (res == 0);
        if (fn != 5) rm[0] = 8'(res);
      end else if (op >= 8'hC0 && op <= 8'hC4) begin
        take = (op == 8'hC0) || (op == 8'hC1 && mz) || (op == 8'hC2 && !mz) ||
               (op == 8'hC3 && mc) || (op == 8'hC4 && !mc);
        if (take) mpc = opd;
      end else if (op != 8'h00) begin
`ifdef MACHINE_ILLEGAL_HALT_EN
        mhalt = 1'b1;
`endif
      end
    end
  endtask

  task automatic load_img();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 256; i++) dut.m_ram.mem[i] = img[i];
  endtask

  // Release reset, wait for halt within a budget, then compare full state with the model.
  task automatic run_to_halt(input string name);
    int n = 0;
    int limit = mcyc + 40;
    @(negedge clk);
    reset = 1'b1;
    while (n < limit && halted !== 1'b1) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, " cycles"}, n, mcyc);
    repeat (4) @(posedge clk);
    #1;
    check({name, " halted"}, halted, 1'b1);
    check({name, " pc"}, dbg_pc, mpc);
    for (int i = 0; i < 8; i++) check($sformatf("%s reg%0d", name, i), dut_reg(i), rm[i]);
    check({name, " Z"}, dut.m_cpu.r_flag_z, mz);
    check({name, " C"}, dut.m_cpu.r_flag_c, mc);
    for (int i = 0; i < 256; i++)
      check($sformatf("%s mem%0h", name, i), dut.m_ram.mem[i], mm[i]);
  endtask

  task automatic run_prog(input string name);
    load_img();
    run_model();
    run_to_halt(name);
  endtask

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
  endtask

  task automatic set_bytes(input logic [7:0] base, input logic [7:0] b [], input int len);
    for (int i = 0; i < len; i++) img[base + 8'(i)] = b[i];
  endtask

  // Random terminating program: forward-only jumps, stores confined to 0x80..0xFF.
  task automatic gen_random();
    int n;
    int kind [32];
    int start [33];
    int addr = 0;
    int r;
    n = $urandom_range(8, 24);
    for (int i = 0; i < 256; i++) img[i] = (i >= 128) ? 8'($urandom_range(0, 255)) : 8'h00;
    for (int i = 0; i < n; i++) begin
      kind[i]  = $urandom_range(0, 7);
      start[i] = addr;
      addr    += (kind[i] inside {0, 1, 2, 5}) ? 2 : 1;
    end
    start[n] = addr;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 7);
      case (kind[i])
        0: begin img[start[i]] = 8'(8 + r);  img[start[i] + 1] = 8'($urandom_range(0, 255)); end
        1: begin img[start[i]] = 8'(16 + r); img[start[i] + 1] = 8'($urandom_range(0, 255)); end
        2: begin img[start[i]] = 8'(24 + r); img[start[i] + 1] = 8'($urandom_range(128, 255)); end
        3: img[start[i]] = 8'($urandom_range(64, 127));
        4: img[start[i]] = 8'($urandom_range(128, 191));
        5: begin
          img[start[i]]     = 8'($urandom_range(192, 196));
          img[start[i] + 1] = 8'(start[$urandom_range(i + 1, n)]);
        end
        6: img[start[i]] = 8'h00;
        default: begin
          case ($urandom_range(0, 2))
            0:       img[start[i]] = 8'($urandom_range(2, 7));
            1:       img[start[i]] = 8'($urandom_range(32, 63));
            default: img[start[i]] = 8'($urandom_range(197, 255));
          endcase
        end
      endcase
    end
    img[start[n]] = 8'h01;
  endtask

  initial begin
    int k;
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("rst pc", dbg_pc, 8'h00);
    check("rst halted", halted, 1'b0);
    for (int i = 0; i < 8; i++) check($sformatf("rst reg%0d", i), dut_reg(i), 8'h00);
    check("rst Z", dut.m_cpu.r_flag_z, 1'b0);
    check("rst C", dut.m_cpu.r_flag_c, 1'b0);

    // LDI A,5; LDI B,3; ADD B; HLT
    clear_img();
    set_bytes(8'h00, '{8'h08, 8'h05, 8'h09, 8'h03, 8'h81, 8'h01}, 6);
    run_prog("add");
    check("add A", dut_reg(0), 8'h08);
    check("add B", dut_reg(1), 8'h03);
    check("add pc", dbg_pc, 8'h06);
    check("add Z", dut.m_cpu.r_flag_z, 1'b0);
    check("add C", dut.m_cpu.r_flag_c, 1'b0);

    // LDI A,3; LDI B,5; SUB B; HLT
    clear_img();
    set_bytes(8'h00, '{8'h08, 8'h03, 8'h09, 8'h05, 8'h89, 8'h01}, 6);
    run_prog("sub");
    check("sub A", dut_reg(0), 8'hFE);
    check("sub C", dut.m_cpu.r_flag_c, 1'b1);
    check("sub Z", dut.m_cpu.r_flag_z, 1'b0);

    // LDI A,FF; LDI B,1; ADD B; JZ 20; HLT; HLT at 0x20
    clear_img();
    set_bytes(8'h00, '{8'h08, 8'hFF, 8'h09, 8'h01, 8'h81, 8'hC1, 8'h20, 8'h01}, 8);
    img[8'h20] = 8'h01;
    run_prog("jz");
    check("jz pc", dbg_pc, 8'h21);
    check("jz A", dut_reg(0), 8'h00);
    check("jz Z", dut.m_cpu.r_flag_z, 1'b1);
    check("jz C", dut.m_cpu.r_flag_c, 1'b1);

    // LDI C,AA; ST C,80; LD D,80; MOV T,D; HLT
    clear_img();
    set_bytes(8'h00, '{8'h0A, 8'hAA, 8'h1A, 8'h80, 8'h13, 8'h80, 8'h7B, 8'h01}, 8);
    run_prog("ldst");
    check("ldst mem80", dut.m_ram.mem[8'h80], 8'hAA);
    check("ldst D", dut_reg(3), 8'hAA);
    check("ldst T", dut_reg(7), 8'hAA);
    check("ldst Z", dut.m_cpu.r_flag_z, 1'b0);
    check("ldst C", dut.m_cpu.r_flag_c, 1'b0);

    // Countdown: LDI A,3; LDI B,1; SUB B; JNZ 04; HLT
    clear_img();
    set_bytes(8'h00, '{8'h08, 8'h03, 8'h09, 8'h01, 8'h89, 8'hC2, 8'h04, 8'h01}, 8);
    run_prog("loop");
    check("loop A", dut_reg(0), 8'h00);
    check("loop cycles", mcyc, 5 + 5 + 3 * (3 + 5) + 3);

    // Illegal opcode, then LDI A,7; HLT
    clear_img();
    set_bytes(8'h00, '{8'hFF, 8'h08, 8'h07, 8'h01}, 4);
    run_prog("illegal");
`ifdef MACHINE_ILLEGAL_HALT_EN
    check("illegal pc", dbg_pc, 8'h01);
    check("illegal A", dut_reg(0), 8'h00);
`else
    check("illegal pc", dbg_pc, 8'h04);
    check("illegal A", dut_reg(0), 8'h07);
`endif

    // Self-modifying: ST turns the LDI at 0x05 into HLT before it is fetched.
    clear_img();
    set_bytes(8'h00, '{8'h08, 8'h01, 8'h18, 8'h05, 8'h00, 8'h09, 8'h77, 8'h01}, 8);
    run_prog("smc");
    check("smc pc", dbg_pc, 8'h06);
    check("smc B", dut_reg(1), 8'h00);
    check("smc mem05", dut.m_ram.mem[8'h05], 8'h01);

    // Long loop with a store inside, interrupted by reset, then rerun from 0x00.
    clear_img();
    set_bytes(8'h00, '{8'h08, 8'h40, 8'h09, 8'h01, 8'h89, 8'h18, 8'h90, 8'hC2, 8'h04, 8'h01},
              10);
    load_img();
    run_model();
    @(negedge clk);
    reset = 1'b1;
    k = $urandom_range(40, 300);
    repeat (k) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("midrst pc", dbg_pc, 8'h00);
    check("midrst halted", halted, 1'b0);
    for (int i = 0; i < 8; i++) check($sformatf("midrst reg%0d", i), dut_reg(i), 8'h00);
    @(posedge clk);
    #1;
    check("midrst edge pc", dbg_pc, 8'h00);
    check("midrst edge A", dut_reg(0), 8'h00);
    for (int i = 0; i < 10; i++)
      check($sformatf("midrst ram%0d", i), dut.m_ram.mem[i], img[i]);
    run_to_halt("rerun");

    for (int t = 0; t < 20; t++) begin
      gen_random();
      run_prog($sformatf("rand%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
